mips_fetch_stage: RTL and testbench

//  Parametrised instruction-fetch stage with an IF/ID pipeline register. Owns the PC,
//  a synchronous-read instruction ROM, stall hold, branch/jump redirect with wrong-path

---
 rtl/mips_pkg.sv | 10 +
 rtl/fetch_imem.sv | 28 ++
 rtl/mips_fetch_stage.sv | 91 +++++++++
 tb/tb_mips_fetch_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: instruction width, NOP encoding,
// PC increment and the default reset vector.
package mips_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_imem.sv
// Synchronous-read instruction ROM. The registered read port doubles as the
// IF/ID instruction register; en freezes it during stall, redirect and reset.
module fetch_imem
  import mips_pkg::*;
#(
  parameter int    IMEM_DEPTH = 256,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] addr,
  output logic [INST_W-1:0]             rdata
);

  logic [INST_W-1:0] mem [IMEM_DEPTH];

  // ROM cleared to NOP at elaboration; contents are supplied by the environment.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = NOP_INST;
  end

  // NOTE: the ROM output register carries no reset; reset and squash
  // values are substituted downstream, which keeps this a plain block-RAM read.
  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection with branch/jump
// redirect and stall hold, and the IF/ID pipeline register feeding decode.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter string           INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              jump,
  input  logic [XLEN-1:0]   jump_target,
  output logic [XLEN-1:0]   fetch_pc,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [XLEN-1:0]   if_id_pc4,
  output logic [INST_W-1:0] if_id_inst,
  output logic              if_id_valid
);

  localparam int              AW       = $clog2(IMEM_DEPTH);
  localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] WORD_MSK = ~XLEN'(3);

  logic [XLEN-1:0]   next_pc;
  logic [XLEN-1:0]   seq_pc;
  logic              squash;
  logic              hold;
  logic              rom_en;
  logic [INST_W-1:0] rom_data;

  assign seq_pc = fetch_pc + STEP;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_pc = seq_pc;
    squash  = 1'b0;
    hold    = 1'b0;
    if (branch_taken) begin
      next_pc = branch_target & WORD_MSK;
      squash  = 1'b1;
    end else if (jump) begin
      next_pc = jump_target & WORD_MSK;
      squash  = 1'b1;
    end else if (stall) begin
      next_pc = fetch_pc;
      hold    = 1'b1;
    end
  end

  assign rom_en = rst & ~stall & ~branch_taken & ~jump;

  fetch_imem #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_imem (
    .clk   (clk),
    .en    (rom_en),
    .addr  (fetch_pc[AW+1:2]),
    .rdata (rom_data)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (squash) begin
      fetch_pc    <= next_pc;
      if_id_valid <= 1'b0;
    end else if (!hold) begin
      fetch_pc    <= next_pc;
      if_id_pc    <= fetch_pc;
      if_id_pc4   <= seq_pc;
      if_id_valid <= 1'b1;
    end
  end

  // The ROM register only holds a real instruction while valid is set;
  // reset and squash both clear valid, so NOP is substituted here.
  assign if_id_inst = if_id_valid ? rom_data : NOP_INST;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: reset, sequential fetch, stall,
// redirects and their priority, PC wrap/aliasing and reset mid-redirect.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] fetch_pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mips_fetch_stage #(
    .XLEN       (32),
    .IMEM_DEPTH (256),
    .RESET_PC   (32'h0000_0000),
    .INIT_FILE  ("")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .fetch_pc      (fetch_pc),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic v);
    check({tag, ".pc"},    if_id_pc,           pc);
    check({tag, ".pc4"},   if_id_pc4,          pc + 32'd4);
    check({tag, ".inst"},  if_id_inst,         inst);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
  endtask

  function automatic logic [31:0] rom(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    #1;
    for (int i = 0; i < 256; i++) dut.u_imem.mem[i] = rom(i);

    // Reset held for two edges
    step(); step();
    check("rst.fetch_pc", fetch_pc, 32'h0);
    check("rst.pc",       if_id_pc, 32'h0);
    check("rst.pc4",      if_id_pc4, 32'h0);
    check("rst.inst",     if_id_inst, 32'h0);
    check("rst.valid",    {31'd0, if_id_valid}, 32'h0);

    // Sequential fetch
    rst = 1'b1;
    step();
    check("seq1.fetch_pc", fetch_pc, 32'h4);
    check_ifid("seq1", 32'h0, rom(0), 1'b1);
    step();
    check("seq2.fetch_pc", fetch_pc, 32'h8);
    check_ifid("seq2", 32'h4, rom(1), 1'b1);

    // Stall for three cycles at fetch_pc=8
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall.fetch_pc", fetch_pc, 32'h8);
      check_ifid("stall", 32'h4, rom(1), 1'b1);
    end
    stall = 1'b0;
    step();
    check("unstall.fetch_pc", fetch_pc, 32'hC);
    check_ifid("unstall", 32'h8, rom(2), 1'b1);

    // Taken branch at fetch_pc=C
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    check("br.fetch_pc", fetch_pc, 32'h40);
    check("br.valid",    {31'd0, if_id_valid}, 32'h0);
    check("br.inst",     if_id_inst, 32'h0);
    check("br.pc_hold",  if_id_pc, 32'h8);
    branch_taken = 1'b0;
    step();
    check("br2.fetch_pc", fetch_pc, 32'h44);
    check_ifid("br2", 32'h40, rom(16), 1'b1);

    // Branch beats jump beats stall
    branch_taken = 1'b1; branch_target = 32'h80;
    jump = 1'b1; jump_target = 32'h20; stall = 1'b1;
    step();
    check("prio.fetch_pc", fetch_pc, 32'h80);
    check("prio.valid",    {31'd0, if_id_valid}, 32'h0);
    branch_taken = 1'b0; jump_target = 32'h23;
    step();
    check("jmp.fetch_pc", fetch_pc, 32'h20);
    check("jmp.valid",    {31'd0, if_id_valid}, 32'h0);
    jump = 1'b0; stall = 1'b0;
    step();
    check("jmp2.fetch_pc", fetch_pc, 32'h24);
    check_ifid("jmp2", 32'h20, rom(8), 1'b1);

    // PC wrap at the top of the address space
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    check("wrap.fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    jump = 1'b0;
    step();
    check("wrap1.fetch_pc", fetch_pc, 32'h0);
    check_ifid("wrap1", 32'hFFFF_FFFC, rom(255), 1'b1);
    step();
    check("wrap2.fetch_pc", fetch_pc, 32'h4);
    check_ifid("wrap2", 32'h0, rom(0), 1'b1);

    // Aliasing beyond the ROM depth
    jump = 1'b1; jump_target = 32'h400;
    step();
    jump = 1'b0;
    step();
    check("alias.fetch_pc", fetch_pc, 32'h404);
    check_ifid("alias", 32'h400, rom(0), 1'b1);

    // Reset during stall + jump
    rst = 1'b0; stall = 1'b1; jump = 1'b1; jump_target = 32'h200;
    step();
    check("rmid.fetch_pc", fetch_pc, 32'h0);
    check("rmid.valid",    {31'd0, if_id_valid}, 32'h0);
    check("rmid.inst",     if_id_inst, 32'h0);
    check("rmid.pc",       if_id_pc, 32'h0);
    rst = 1'b1; stall = 1'b0; jump = 1'b0;
    step();
    check("rrel.fetch_pc", fetch_pc, 32'h4);
    check_ifid("rrel", 32'h0, rom(0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
